// File: rtl/lsu_access_pkg.sv
// Shared constants and types for the load/store unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lsu_access_pkg;

    localparam int XLEN       = 32;
    localparam int STRB_WIDTH = XLEN / 8;

    // Access size codes; the reserved code is handled as a byte access.
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    typedef struct packed {
        logic            we;
        logic            uns;
        logic [1:0]      size;
        logic [XLEN-1:0] addr;
    } acc_t;

endpackage

// File: rtl/lsu_access_if.sv
// Data-memory bus: req/gnt request phase, rvalid response phase.
// Latency: wires only.
// Backpressure: master holds req and payload until gnt.
interface lsu_access_if;
    import lsu_access_pkg::*;

    logic                  req;
    logic                  we;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  gnt;
    logic                  rvalid;
    logic [XLEN-1:0]       rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/lsu_access_align.sv
// Store lane packing with byte strobes, load lane extraction with sign/zero extension.
// Latency: combinational.
// Backpressure: none.
module lsu_access_align
    import lsu_access_pkg::*;
(
    input  logic [1:0]            st_size,
    input  logic [1:0]            st_off,
    input  logic [XLEN-1:0]       st_data,
    output logic [XLEN-1:0]       st_wdata,
    output logic [STRB_WIDTH-1:0] st_wstrb,
    input  logic [1:0]            ld_size,
    input  logic                  ld_uns,
    input  logic [1:0]            ld_off,
    input  logic [XLEN-1:0]       ld_word,
    output logic [XLEN-1:0]       ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'hF;
        case (st_size)
            LS_BYTE, LS_RSVD: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            LS_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << {st_off[1], 1'b0};
            end
            LS_WORD: begin
                st_wdata = st_data;
                st_wstrb = 4'hF;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_off)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            LS_BYTE, LS_RSVD: ld_data = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
            LS_HALF:          ld_data = {{16{~ld_uns & ld_half[15]}}, ld_half};
            LS_WORD:          ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_access.sv
// Load/store unit: one data-memory access per accepted request, load result to writeback.
// Latency: zero-wait bus gives req at T+1, wb pulse at T+3, ready again at T+4.
// Backpressure: lsu_ready low from accept until the cycle after DONE; bus req held until gnt.
module lsu_access
    import lsu_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  de_alu_l_flag,
    input  logic                  de_alu_s_flag,
    input  logic [1:0]            de_alu_ls_size,
    input  logic                  de_lsu_unsigned,
    input  logic [RD_WIDTH-1:0]   de_lsu_rd,
    input  logic [DATA_WIDTH-1:0] alu_lsu_addr,
    input  logic [DATA_WIDTH-1:0] reg2_data,
    input  logic                  alu_int_l_misa,
    input  logic                  alu_int_s_misa,
    input  logic                  lsu_flush,
    lsu_access_if.master          mem,
    output logic                  lsu_wb_valid,
    output logic [RD_WIDTH-1:0]   lsu_wb_rd,
    output logic [DATA_WIDTH-1:0] lsu_wb_data,
    output logic                  lsu_int_fault,
    output logic [DATA_WIDTH-1:0] lsu_int_fault_addr
);

    logic [1:0]            state;
    acc_t                  acc_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic                  kill_q;

    logic                  accept;
    logic                  issued;
    logic                  resp_vld;
    logic                  kill_nxt;
    logic [XLEN-1:0]       st_wdata;
    logic [STRB_WIDTH-1:0] st_wstrb;
    logic [XLEN-1:0]       ld_data;

    assign lsu_ready = (state == ST_IDLE);
    assign accept    = lsu_ready & lsu_valid & (de_alu_l_flag | de_alu_s_flag)
                       & ~alu_int_l_misa & ~alu_int_s_misa;

    // Once granted the access is on the bus; a flush can only suppress its result.
    assign issued    = (state == ST_WAIT) | ((state == ST_REQ) & mem.gnt);
    assign resp_vld  = issued & mem.rvalid;
    assign kill_nxt  = kill_q | (issued & lsu_flush);

    lsu_access_align u_align (
        .st_size  (de_alu_ls_size),
        .st_off   (alu_lsu_addr[1:0]),
        .st_data  (reg2_data),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_size  (acc_q.size),
        .ld_uns   (acc_q.uns),
        .ld_off   (acc_q.addr[1:0]),
        .ld_word  (mem.rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            acc_q              <= '0;
            rd_q               <= '0;
            kill_q             <= 1'b0;
            mem.req            <= 1'b0;
            mem.we             <= 1'b0;
            mem.addr           <= '0;
            mem.wdata          <= '0;
            mem.wstrb          <= '0;
            lsu_wb_valid       <= 1'b0;
            lsu_wb_rd          <= '0;
            lsu_wb_data        <= '0;
            lsu_int_fault      <= 1'b0;
            lsu_int_fault_addr <= '0;
        end else begin
            lsu_wb_valid  <= 1'b0;
            lsu_int_fault <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc_q.we   <= de_alu_s_flag;
                        acc_q.uns  <= de_lsu_unsigned;
                        acc_q.size <= de_alu_ls_size;
                        acc_q.addr <= alu_lsu_addr;
                        rd_q       <= de_lsu_rd;
                        kill_q     <= 1'b0;
                        mem.req    <= 1'b1;
                        mem.we     <= de_alu_s_flag;
                        mem.addr   <= {alu_lsu_addr[XLEN-1:2], 2'b00};
                        mem.wdata  <= st_wdata;
                        mem.wstrb  <= de_alu_s_flag ? st_wstrb : '0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem.gnt) begin
                        mem.req <= 1'b0;
                        kill_q  <= kill_nxt;
                        state   <= mem.rvalid ? ST_DONE : ST_WAIT;
                    end else if (lsu_flush) begin
                        mem.req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    kill_q <= kill_nxt;
                    if (mem.rvalid) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    kill_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase

            // Result pulses are registered on entry to DONE so they show during DONE.
            if (resp_vld) begin
                if (~acc_q.we & ~mem.err & ~kill_nxt) begin
                    lsu_wb_valid <= 1'b1;
                    lsu_wb_rd    <= rd_q;
                    lsu_wb_data  <= ld_data;
                end
                if (mem.err & ~kill_nxt) begin
                    lsu_int_fault      <= 1'b1;
                    lsu_int_fault_addr <= acc_q.addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_access.sv
// Randomized bench for lsu_access with a transaction-level expectation model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        l_flag, s_flag;
    logic [1:0]  ls_size;
    logic        ls_uns;
    logic [4:0]  ls_rd;
    logic [31:0] ls_addr, st_data;
    logic        l_misa, s_misa;
    logic        lsu_flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    lsu_access_if mem_if ();

    lsu_access #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lsu_valid          (lsu_valid),
        .lsu_ready          (lsu_ready),
        .de_alu_l_flag      (l_flag),
        .de_alu_s_flag      (s_flag),
        .de_alu_ls_size     (ls_size),
        .de_lsu_unsigned    (ls_uns),
        .de_lsu_rd          (ls_rd),
        .alu_lsu_addr       (ls_addr),
        .reg2_data          (st_data),
        .alu_int_l_misa     (l_misa),
        .alu_int_s_misa     (s_misa),
        .lsu_flush          (lsu_flush),
        .mem                (mem_if),
        .lsu_wb_valid       (wb_valid),
        .lsu_wb_rd          (wb_rd),
        .lsu_wb_data        (wb_data),
        .lsu_int_fault      (fault),
        .lsu_int_fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Expected DUT view for the cycle following the next rising edge.
    logic        exp_req = 1'b0, exp_ready = 1'b1, exp_wb = 1'b0, exp_fault = 1'b0;
    logic        e_we = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_data = '0, e_faddr = '0;
    logic [3:0]  e_wstrb = '0;
    logic [4:0]  e_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 1;
    endfunction

    function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return 4'(((1 << n) - 1) << lane_off(sz, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] w);
        int n = nbytes(sz);
        logic [31:0] v, mask;
        if (n == 4) return w;
        mask = (32'h1 << (8*n)) - 32'h1;
        v = (w >> (8*lane_off(sz, a))) & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                chk("lsu_ready", lsu_ready, exp_ready);
                chk("mem_req", mem_if.req, exp_req);
                if (exp_req) begin
                    chk("mem_addr", mem_if.addr, e_addr);
                    chk("mem_we", mem_if.we, e_we);
                    chk("mem_wstrb", mem_if.wstrb, e_wstrb);
                    if (e_we) chk("mem_wdata", mem_if.wdata, e_wdata);
                end
                chk("wb_valid", wb_valid, exp_wb);
                if (exp_wb) begin
                    chk("wb_rd", wb_rd, e_rd);
                    chk("wb_data", wb_data, e_data);
                end
                chk("fault", fault, exp_fault);
                if (exp_fault) chk("fault_addr", fault_addr, e_faddr);
            end
        end
    end

    // fm: 0 none, 1 flush in REQ before gnt (at pre-gnt cycle fl_at), 2 flush in WAIT.
    task automatic run_txn(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                           input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input logic err, input int gd, input int rvd,
                           input int fm, input int fl_at, input logic done_flush, input logic stray);
        int   n     = nbytes(sz);
        logic misa  = (int'(a % 4) % n) != 0;
        logic acc   = (ld | st) & ~misa;
        logic kill  = 1'b0;
        @(negedge clk);
        lsu_valid = 1'b1; l_flag = ld; s_flag = st; ls_size = sz; ls_uns = uns;
        ls_rd = rd; ls_addr = a; st_data = d; l_misa = ld & misa; s_misa = st & misa;
        if (acc) begin
            exp_req = 1'b1; exp_ready = 1'b0;
            e_addr = {a[31:2], 2'b00}; e_we = st;
            e_wstrb = st ? m_strb(sz, a) : 4'h0; e_wdata = m_wdata(sz, d);
        end
        @(negedge clk);
        lsu_valid = 1'b0; l_misa = 1'b0; s_misa = 1'b0;
        ls_addr = $urandom; st_data = $urandom; ls_rd = 5'($urandom); ls_size = 2'($urandom);
        if (!acc) begin
            repeat (2) begin
                mem_if.rvalid = stray; mem_if.rdata = $urandom; mem_if.err = 1'($urandom);
                @(negedge clk);
            end
            mem_if.rvalid = 1'b0;
            return;
        end
        for (int i = 0; i < gd; i++) begin
            if (fm == 1 && i == fl_at) begin
                lsu_flush = 1'b1; exp_req = 1'b0; exp_ready = 1'b1;
                @(negedge clk);
                lsu_flush = 1'b0;
                return;
            end
            mem_if.rvalid = stray; mem_if.rdata = $urandom; mem_if.err = 1'($urandom);
            @(negedge clk);
            mem_if.rvalid = 1'b0;
        end
        mem_if.gnt = 1'b1; exp_req = 1'b0;
        for (int i = 0; i < rvd; i++) begin
            if (i > 0) begin
                if (fm == 2 && i == 1) begin
                    lsu_flush = 1'b1; kill = 1'b1;
                end
            end
            @(negedge clk);
            mem_if.gnt = 1'b0; lsu_flush = 1'b0;
        end
        mem_if.rvalid = 1'b1; mem_if.rdata = rdata; mem_if.err = err;
        if (!kill) begin
            exp_wb = ld & ~err; exp_fault = err;
            e_rd = rd; e_data = m_load(sz, uns, a, rdata); e_faddr = a;
        end
        @(negedge clk);
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.err = 1'b0;
        exp_wb = 1'b0; exp_fault = 1'b0; exp_ready = 1'b1;
        lsu_flush = done_flush;
        @(negedge clk);
        lsu_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; lsu_valid = 1'b0; l_flag = 1'b0; s_flag = 1'b0; ls_size = 2'b00;
        ls_uns = 1'b0; ls_rd = '0; ls_addr = '0; st_data = '0; l_misa = 1'b0; s_misa = 1'b0;
        lsu_flush = 1'b0;
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0; mem_if.err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", lsu_ready, 32'd1);
        chk("rst_req", mem_if.req, 32'd0);
        chk("rst_we", mem_if.we, 32'd0);
        chk("rst_addr", mem_if.addr, 32'd0);
        chk("rst_wdata", mem_if.wdata, 32'd0);
        chk("rst_wstrb", mem_if.wstrb, 32'd0);
        chk("rst_wb_valid", wb_valid, 32'd0);
        chk("rst_wb_rd", wb_rd, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault", fault, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);

        chk("model_sb_strb", m_strb(2'b00, 32'h103), 32'h8);
        chk("model_sb_wdata", m_wdata(2'b00, 32'hA5), 32'hA5A5A5A5);
        chk("model_sh_strb", m_strb(2'b01, 32'h102), 32'hC);
        chk("model_sh_wdata", m_wdata(2'b01, 32'h1234), 32'h12341234);
        chk("model_lb", m_load(2'b00, 1'b0, 32'h101, 32'h000080FF), 32'hFFFFFF80);
        chk("model_lbu", m_load(2'b00, 1'b1, 32'h101, 32'h000080FF), 32'h00000080);
        chk("model_lh", m_load(2'b01, 1'b0, 32'h102, 32'h80010000), 32'hFFFF8001);

        rst_n = 1'b1;
        chk_en = 1'b1;

        //       ld    st    sz     uns   rd     addr        data          rdata         err  gd rvd fm fl df   stray
        run_txn(1'b0, 1'b1, 2'b10, 1'b0, 5'd0,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 2'b00, 1'b0, 5'd0,  32'h103, 32'h000000A5, 32'h0,        1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 5'd0,  32'h102, 32'h00001234, 32'h0,        1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b00, 1'b0, 5'd7,  32'h101, 32'h0,        32'h000080FF, 1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b00, 1'b1, 5'd8,  32'h101, 32'h0,        32'h000080FF, 1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b01, 1'b0, 5'd31, 32'h102, 32'h0,        32'h80010000, 1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 5'd3,  32'h200, 32'h0,        32'hCAFEF00D, 1'b0, 3, 0, 0, 0, 1'b0, 1'b1);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 5'd4,  32'h204, 32'h0,        32'h11111111, 1'b0, 3, 1, 1, 1, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 5'd5,  32'h208, 32'h0,        32'h22222222, 1'b0, 0, 3, 2, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 5'd6,  32'h20C, 32'h0,        32'h33333333, 1'b1, 1, 2, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 5'd9,  32'h102, 32'h0,        32'h0,        1'b0, 0, 1, 0, 0, 1'b0, 1'b1);
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 5'd9,  32'h300, 32'h0,        32'h0,        1'b0, 0, 1, 0, 0, 1'b0, 1'b1);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 5'd10, 32'h310, 32'h0,        32'h44444444, 1'b0, 0, 1, 0, 0, 1'b1, 1'b0);

        for (int t = 0; t < 300; t++) begin
            int          op  = $urandom_range(0, 9);
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            logic [31:0] a   = $urandom;
            int          gd  = $urandom_range(0, 3);
            int          rvd = $urandom_range(0, 3);
            int          fm  = 0;
            int          fl  = 0;
            int          sel = $urandom_range(0, 5);
            if ($urandom_range(0, 4) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
            if (sel == 0 && gd >= 1) begin
                fm = 1; fl = $urandom_range(0, gd - 1);
            end else if (sel == 1 && rvd >= 2) begin
                fm = 2;
            end
            run_txn(op >= 1 && op <= 4, op >= 5, sz, 1'($urandom), 5'($urandom), a, $urandom,
                    $urandom, $urandom_range(0, 6) == 0, gd, rvd, fm, fl,
                    1'($urandom), 1'($urandom));
        end

        // Reset while a request is pending must drop the bus request at once.
        @(negedge clk);
        lsu_valid = 1'b1; l_flag = 1'b1; s_flag = 1'b0; ls_size = 2'b10; ls_addr = 32'h400;
        exp_req = 1'b1; exp_ready = 1'b0; e_addr = 32'h400; e_we = 1'b0; e_wstrb = 4'h0;
        @(negedge clk);
        lsu_valid = 1'b0;
        rst_n = 1'b0; exp_req = 1'b0; exp_ready = 1'b1;
        #1;
        chk("mid_rst_req", mem_if.req, 32'd0);
        chk("mid_rst_ready", lsu_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
